// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word fetches to a
// variable-latency instruction memory over req/ack, buffers returned words
// with their PC+4 in a small FIFO and hands them to ID under valid/ready.
// Redirects from EX flush the FIFO; a fetch still in flight at redirect time
// is allowed to complete at its old address and its data is dropped.

module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus_4
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_DISCARD = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [31:0]        fetch_pc_r;
    logic [31:0]        fetch_pc_next_s;
    logic [31:0]        saved_pc_r;
    logic [31:0]        saved_pc_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [31:0]        instr_q_r [DEPTH];
    logic [31:0]        pc4_q_r   [DEPTH];
    logic [31:0]        redirect_pc_s;
    logic               queue_nonempty_s;
    logic               push_s;
    logic               pop_s;

    // The low two address bits of a redirect target are forced to zero.
    assign redirect_pc_s    = redirect_pc & 32'hFFFF_FFFC;
    assign queue_nonempty_s = (count_r != {CNT_W{1'b0}});

    // A redirect wins over both pop and push in the same cycle.
    assign pop_s        = queue_nonempty_s & id_ready & ~redirect;
    assign push_s       = (state_r == ST_REQ) & imem_ack & ~redirect;
    assign count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

    // Next-state, next fetch PC and saved redirect target.
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        saved_pc_next_s = saved_pc_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_next_s = redirect_pc_s;
                    state_next_s    = ST_REQ;
                end else if (count_next_s < DEPTH_C) begin
                    state_next_s    = ST_REQ;
                end else begin
                    state_next_s    = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returned word belongs to the wrong path; refetch.
                        fetch_pc_next_s = redirect_pc_s;
                        state_next_s    = ST_REQ;
                    end else begin
                        fetch_pc_next_s = fetch_pc_r + 32'd4;
                        state_next_s    = (count_next_s == DEPTH_C) ? ST_IDLE : ST_REQ;
                    end
                end else if (redirect) begin
                    // Old request must still complete before the new one.
                    saved_pc_next_s = redirect_pc_s;
                    state_next_s    = ST_DISCARD;
                end else begin
                    state_next_s    = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    saved_pc_next_s = redirect_pc_s;
                end else begin
                    saved_pc_next_s = saved_pc_r;
                end
                if (imem_ack) begin
                    fetch_pc_next_s = redirect ? redirect_pc_s : saved_pc_r;
                    state_next_s    = ST_REQ;
                end else begin
                    state_next_s    = ST_DISCARD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, fetch PC and saved redirect target registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            saved_pc_r <= RESET_PC;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            saved_pc_r <= saved_pc_next_s;
        end
    end

    // Queue occupancy and pointers; a redirect empties the queue in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (redirect) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            count_r <= count_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Queue storage; contents are only observable through count_r, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_q_r[wr_ptr_r] <= imem_rdata;
            pc4_q_r[wr_ptr_r]   <= fetch_pc_r + 32'd4;
        end
    end

    // Outputs are decoded directly from registered state.
    assign imem_req     = (state_r == ST_REQ) | (state_r == ST_DISCARD);
    assign imem_addr    = fetch_pc_r;
    assign id_valid     = queue_nonempty_s;
    assign id_instr     = queue_nonempty_s ? instr_q_r[rd_ptr_r] : 32'h0000_0000;
    assign id_pc_plus_4 = queue_nonempty_s ? pc4_q_r[rd_ptr_r]   : 32'h0000_0000;

endmodule
